v2x_spi_slave: RTL and testbench

SPI mode-0 slave front end for the V2X HSM. It sits directly upstream of `v2x_protocol_router`. It oversamples the external SPI pins in the `i_sys_clk` domain and deframes MOSI into 16-bit words, which it delivers as single-cycle `o_rx_valid` pulses. It serialises router response words onto MISO from a one-entry holding register that uses a valid/ready handshake.

---
 rtl/v2x_spi_slave.sv | 161 ++++++++++++++++
 tb/tb_v2x_spi_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/v2x_spi_slave.sv
// rtl/v2x_spi_slave.sv - SPI mode-0 slave front end with one-entry response holding register
// Optional busy fill word on underrun: define V2X_SPI_BUSY_FILL_EN.
module v2x_spi_slave #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_spi_sclk,
    input  logic                  i_spi_cs_n,
    input  logic                  i_spi_mosi,
    output logic                  o_spi_miso,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    input  logic                  i_busy,
    output logic                  o_frame_error
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int SW = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_prev_q, cs_prev_q, mosi_dly_q;
    logic                   sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;

    state_e                 state_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [SW-1:0]          settle_q;
    logic                   first_q, hold_full_q, miso_q, rx_valid_q, frame_err_q;
    logic [DATA_WIDTH-2:0]  rx_shift_q, tx_shift_q;
    logic [DATA_WIDTH-1:0]  hold_q, rx_data_q;
    logic [DATA_WIDTH-1:0]  fill_word, load_word;
    logic                   do_load, accept;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Edge pulses are registered so that mosi_dly_q is aligned with the sampled SCLK rise.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            mosi_dly_q  <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            mosi_dly_q  <= mosi_s;
            sclk_rise_q <= sclk_s & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_s & sclk_prev_q;
            cs_rise_q   <= cs_s & ~cs_prev_q;
            cs_fall_q   <= ~cs_s & cs_prev_q;
        end
    end

`ifdef V2X_SPI_BUSY_FILL_EN
    assign fill_word = i_busy ? DATA_WIDTH'(16'hB5B5) : '0;
`else
    logic unused_busy;
    assign unused_busy = i_busy;
    assign fill_word   = '0;
`endif

    assign load_word = hold_full_q ? hold_q : fill_word;
    assign accept    = i_tx_valid && !hold_full_q;
    assign do_load   = (state_q == IDLE && cs_fall_q) ||
                       (state_q == ACTIVE && !cs_rise_q && sclk_fall_q &&
                        bit_cnt_q == '0 && !first_q);

    // ARMED lets the synchroniser flush before trusting cs_n, so a frame open at reset is skipped.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q     <= ARMED;
            bit_cnt_q   <= '0;
            settle_q    <= '0;
            first_q     <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (accept) begin
                hold_q      <= i_tx_data;
                hold_full_q <= 1'b1;
            end else if (do_load && hold_full_q) begin
                hold_full_q <= 1'b0;
            end
            if (do_load) begin
                tx_shift_q <= load_word[DATA_WIDTH-2:0];
                miso_q     <= load_word[DATA_WIDTH-1];
            end
            case (state_q)
                ARMED: begin
                    if (settle_q != SETTLE) begin
                        settle_q <= settle_q + 1'b1;
                    end else if (cs_prev_q) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_fall_q) begin
                        state_q   <= ACTIVE;
                        bit_cnt_q <= '0;
                        first_q   <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_rise_q) begin
                        if (bit_cnt_q != '0) begin
                            frame_err_q <= 1'b1;
                        end
                        bit_cnt_q <= '0;
                        miso_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (sclk_rise_q) begin
                        rx_shift_q <= {rx_shift_q[DATA_WIDTH-3:0], mosi_dly_q};
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                        first_q    <= 1'b0;
                        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                            rx_data_q  <= {rx_shift_q, mosi_dly_q};
                            rx_valid_q <= 1'b1;
                        end
                    end else if (sclk_fall_q && !do_load) begin
                        tx_shift_q <= {tx_shift_q[DATA_WIDTH-3:0], 1'b0};
                        miso_q     <= tx_shift_q[DATA_WIDTH-2];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_spi_miso    = miso_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_tx_ready    = ~hold_full_q;
    assign o_frame_error = frame_err_q;

endmodule

// File: tb/tb_v2x_spi_slave.sv
// tb/tb_v2x_spi_slave.sv - randomized self-checking bench for v2x_spi_slave
`timescale 1ns/1ps
module tb_v2x_spi_slave;
    localparam int SS   = 2;
    localparam int HALF = 8;
`ifdef V2X_SPI_BUSY_FILL_EN
    localparam logic [15:0] BUSY_FILL = 16'hB5B5;
`else
    localparam logic [15:0] BUSY_FILL = 16'h0000;
`endif

    logic        i_sys_clk = 1'b0;
    logic        i_sys_rst_n = 1'b0;
    logic        i_spi_sclk = 1'b0;
    logic        i_spi_cs_n = 1'b1;
    logic        i_spi_mosi = 1'b0;
    logic        o_spi_miso;
    logic [15:0] o_rx_data;
    logic        o_rx_valid;
    logic [15:0] i_tx_data = '0;
    logic        i_tx_valid = 1'b0;
    logic        o_tx_ready;
    logic        i_busy = 1'b0;
    logic        o_frame_error;

    v2x_spi_slave #(.DATA_WIDTH(16), .SYNC_STAGES(SS)) dut (
        .i_sys_clk    (i_sys_clk),
        .i_sys_rst_n  (i_sys_rst_n),
        .i_spi_sclk   (i_spi_sclk),
        .i_spi_cs_n   (i_spi_cs_n),
        .i_spi_mosi   (i_spi_mosi),
        .o_spi_miso   (o_spi_miso),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
        .i_tx_data    (i_tx_data),
        .i_tx_valid   (i_tx_valid),
        .o_tx_ready   (o_tx_ready),
        .i_busy       (i_busy),
        .o_frame_error(o_frame_error)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rise16_cyc = 0;
    int          err_pending = 0;
    logic [15:0] exp_rx_q[$];
    bit          model_full = 0;
    logic [15:0] model_hold = '0;
    logic        model_busy = 1'b0;
    logic [15:0] got_tx[3];
    logic [15:0] exp_tx[3];
    logic [15:0] last_rx = '0;
    bit          mon_en = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ferr = 1'b0;

    always @(posedge i_sys_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, req);
        end
    endtask

    // Word the slave must ship at a load point: the held response, else the fill word.
    function automatic logic [15:0] model_load();
        logic [15:0] w;
        if (model_full) begin
            w = model_hold;
            model_full = 0;
        end else begin
            w = model_busy ? BUSY_FILL : 16'h0000;
        end
        return w;
    endfunction

    always @(negedge i_sys_clk) begin
        if (mon_en && i_sys_rst_n) begin
            if (o_rx_valid) begin
                check("rx_pulse_width", {31'd0, prev_valid}, 32'd0);
                check("rx_latency", cyc - rise16_cyc, SS + 2);
                if (exp_rx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: data=%h want=no pulse", o_rx_data);
                end else begin
                    check("rx_data", {16'd0, o_rx_data}, {16'd0, exp_rx_q.pop_front()});
                end
                last_rx = o_rx_data;
            end
            if (o_frame_error) begin
                check("ferr_pulse_width", {31'd0, prev_ferr}, 32'd0);
                total++;
                if (err_pending == 0) begin
                    bad++;
                    $display("FAIL ferr_unexpected: got=1 want=0");
                end else begin
                    err_pending--;
                end
            end
        end
        prev_valid = o_rx_valid;
        prev_ferr  = o_frame_error;
    end

    task automatic spi_bit(input logic mo, input bit last, output logic mi);
        i_spi_mosi = mo;
        repeat (HALF) @(posedge i_sys_clk);
        #1;
        mi = o_spi_miso;
        i_spi_sclk = 1'b1;
        if (last) rise16_cyc = cyc;
        repeat (HALF) @(posedge i_sys_clk);
        #1 i_spi_sclk = 1'b0;
    endtask

    task automatic write_tx(input logic [15:0] v);
        @(negedge i_sys_clk);
        check("tx_ready_before_write", {31'd0, o_tx_ready}, {31'd0, !model_full});
        i_tx_valid = 1'b1;
        i_tx_data  = v;
        @(posedge i_sys_clk);
        #1 i_tx_valid = 1'b0;
        model_hold = v;
        model_full = 1;
        check("tx_ready_after_write", {31'd0, o_tx_ready}, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_miso", {31'd0, o_spi_miso}, 32'd0);
        check("rst_rx_data", {16'd0, o_rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, o_rx_valid}, 32'd0);
        check("rst_tx_ready", {31'd0, o_tx_ready}, 32'd1);
        check("rst_frame_error", {31'd0, o_frame_error}, 32'd0);
    endtask

    task automatic run_frame(input int nw, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input int abort_bits, input logic busy,
                             input int wr_at, input logic [15:0] wr_val);
        logic [15:0] words[3];
        logic        mb;
        int          nbits;
        words = '{w0, w1, w2};
        i_busy = busy;
        model_busy = busy;
        @(posedge i_sys_clk);
        #1 i_spi_cs_n = 1'b0;
        exp_tx[0] = model_load();
        repeat (HALF) @(posedge i_sys_clk);
        #1;
        check("tx_ready_after_load", {31'd0, o_tx_ready}, {31'd0, !model_full});
        for (int w = 0; w < nw; w++) begin
            nbits = (w == nw - 1 && abort_bits > 0) ? abort_bits : 16;
            got_tx[w] = '0;
            for (int b = 0; b < nbits; b++) begin
                if (b == 15) exp_rx_q.push_back(words[w]);
                spi_bit(words[w][15-b], b == 15, mb);
                got_tx[w] = {got_tx[w][14:0], mb};
                if (b == 8 && w == wr_at && !model_full) write_tx(wr_val);
            end
            if (nbits == 16) begin
                check("miso_word", {16'd0, got_tx[w]}, {16'd0, exp_tx[w]});
                if (w < 2) exp_tx[w+1] = model_load();
                else void'(model_load());
            end else begin
                err_pending++;
            end
        end
        repeat (HALF) @(posedge i_sys_clk);
        #1 i_spi_cs_n = 1'b1;
        repeat (HALF + 4) @(posedge i_sys_clk);
        #1;
        check("rx_drained", exp_rx_q.size(), 32'd0);
        check("ferr_drained", err_pending, 32'd0);
        check("miso_idle", {31'd0, o_spi_miso}, 32'd0);
        i_busy = 1'b0;
    endtask

    initial begin
        logic mb;
        int   nw, ab, wa;
        logic [15:0] rw;

        repeat (10) @(posedge i_sys_clk);
        #1;
        check_reset_outputs();
        i_sys_rst_n = 1'b1;
        mon_en = 1;
        repeat (20) @(posedge i_sys_clk);
        #1;

        run_frame(1, 16'h0200, 16'h0, 16'h0, 0, 1'b0, -1, 16'h0);
        check("single_rx_literal", {16'd0, last_rx}, 32'h0200);
        check("single_miso_literal", {16'd0, got_tx[0]}, 32'h0000);

        write_tx(16'hDEAD);
        run_frame(1, 16'h6162, 16'h0, 16'h0, 0, 1'b0, -1, 16'h0);
        check("duplex_miso_literal", {16'd0, got_tx[0]}, 32'hDEAD);
        check("duplex_rx_literal", {16'd0, last_rx}, 32'h6162);

        run_frame(2, 16'h0200, 16'h6162, 16'h0, 0, 1'b0, 0, 16'hCAFE);
        check("b2b_word2_literal", {16'd0, got_tx[1]}, 32'hCAFE);
        check("b2b_rx_literal", {16'd0, last_rx}, 32'h6162);
        run_frame(2, 16'h0200, 16'h6162, 16'h0, 0, 1'b1, -1, 16'h0);
        check("busy_word2_literal", {16'd0, got_tx[1]}, {16'd0, BUSY_FILL});

        run_frame(1, 16'h5A5A, 16'h0, 16'h0, 7, 1'b0, -1, 16'h0);
        run_frame(1, 16'h1234, 16'h0, 16'h0, 0, 1'b0, -1, 16'h0);
        check("after_abort_literal", {16'd0, last_rx}, 32'h1234);

        // Reset with chip select held low in the middle of a word.
        rw = 16'h9C3E;
        @(posedge i_sys_clk);
        #1 i_spi_cs_n = 1'b0;
        repeat (HALF) @(posedge i_sys_clk);
        #1;
        for (int b = 0; b < 8; b++) spi_bit(rw[15-b], 1'b0, mb);
        i_sys_rst_n = 1'b0;
        model_full = 0;
        repeat (3) @(posedge i_sys_clk);
        #1;
        check_reset_outputs();
        i_sys_rst_n = 1'b1;
        for (int b = 8; b < 16; b++) spi_bit(rw[15-b], 1'b0, mb);
        repeat (HALF) @(posedge i_sys_clk);
        #1 i_spi_cs_n = 1'b1;
        repeat (HALF + 4) @(posedge i_sys_clk);
        #1;
        check("armed_no_ferr", err_pending, 32'd0);
        run_frame(1, 16'hABCD, 16'h0, 16'h0, 0, 1'b0, -1, 16'h0);
        check("post_reset_literal", {16'd0, last_rx}, 32'hABCD);

        for (int i = 0; i < 30; i++) begin
            nw = int'($urandom_range(1, 3));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
            wa = int'($urandom_range(0, 3)) - 1;
            if (!model_full && $urandom_range(0, 1) == 1) write_tx(16'($urandom));
            run_frame(nw, 16'($urandom), 16'($urandom), 16'($urandom), ab,
                      1'($urandom_range(0, 1)), wa, 16'($urandom));
        end

        check("final_rx_queue", exp_rx_q.size(), 32'd0);
        check("final_ferr", err_pending, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
